// File: rtl/vectrex_pkg.sv
// Shared definitions for the Vectrex cart upload path: address widths, the
// fill byte returned for unmapped addresses, and the upload FSM state type.
package vectrex_pkg;

   localparam int unsigned CART_ADDR_W  = 15;
   localparam int unsigned IOCTL_ADDR_W = 25;
   localparam logic [7:0]  FILL_BYTE    = 8'hFF;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StFetch = 2'd2
   } upload_state_t;

   // An address maps onto the cart when no bit above the 32 KiB window is set
   // and no bit outside the (2^n-1) size mask is set.
   function automatic logic addr_in_range(input logic [IOCTL_ADDR_W-1:0] addr,
                                          input logic [CART_ADDR_W-1:0]  mask);
      return (addr[IOCTL_ADDR_W-1:CART_ADDR_W] == '0) &&
             ((addr[CART_ADDR_W-1:0] & ~mask) == '0);
   endfunction

endpackage

// File: rtl/cart_upload_if.sv
// HPS ioctl read channel used during a cart upload session.
// master = HPS side (issues reads), slave = cart_upload (returns bytes).
interface cart_upload_if;

   logic                                ioctl_upload;
   logic                                ioctl_rd;
   logic [vectrex_pkg::IOCTL_ADDR_W-1:0] ioctl_addr;
   logic [7:0]                          ioctl_din;
   logic                                ioctl_wait;

   modport master (
      output ioctl_upload,
      output ioctl_rd,
      output ioctl_addr,
      input  ioctl_din,
      input  ioctl_wait
   );

   modport slave (
      input  ioctl_upload,
      input  ioctl_rd,
      input  ioctl_addr,
      output ioctl_din,
      output ioctl_wait
   );

endinterface

// File: rtl/ioctl_edge.sv
// Rising/falling edge detector for the ioctl_upload session flag.
module ioctl_edge (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic rise,
   output logic fall
);

   logic level_prev;

   // Remember last cycle's level so edges show up combinationally this cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         level_prev <= 1'b0;
      end else begin
         level_prev <= level;
      end
   end

   assign rise = level & ~level_prev;
   assign fall = ~level & level_prev;

endmodule

// File: rtl/cart_upload.sv
// Cart upload engine: serves HPS ioctl byte reads from cart memory.
// In-range requests issue one mem_rd and return mem_data MEM_LAT cycles later;
// out-of-range requests return FILL_BYTE after one cycle.
// Optional: define CART_UPLOAD_CHECKSUM_EN to add a mod-256 checksum output.
module cart_upload
   import vectrex_pkg::*;
#(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   cart_upload_if.slave           ioctl,
   input  logic [CART_ADDR_W-1:0] size_mask,
   output logic [CART_ADDR_W-1:0] mem_addr,
   output logic                   mem_rd,
   input  logic [7:0]             mem_data,
   output logic [15:0]            byte_count,
   output logic                   upload_done
`ifdef CART_UPLOAD_CHECKSUM_EN
   ,
   output logic [7:0]             checksum
`endif
);

   upload_state_t state;
   logic [2:0]    lat_cnt;
   logic [7:0]    rd_data;
   logic          busy;

   logic          up_rise;
   logic          up_fall;
   logic          req;
   logic          in_range;
   logic          ret_valid;
   logic [7:0]    ret_byte;

   ioctl_edge u_edge (
      .clock (clock),
      .reset (reset),
      .level (ioctl.ioctl_upload),
      .rise  (up_rise),
      .fall  (up_fall)
   );

   // Decode the incoming request and flag the cycle in which a byte is returned.
   always_comb begin
      req       = ioctl.ioctl_upload & ioctl.ioctl_rd;
      in_range  = addr_in_range(ioctl.ioctl_addr, size_mask);
      ret_valid = 1'b0;
      ret_byte  = FILL_BYTE;
      if (state == StIdle) begin
         ret_valid = req & ~in_range;
      end else if (state == StFetch) begin
         ret_valid = ioctl.ioctl_upload && (lat_cnt == 3'(MEM_LAT));
         ret_byte  = mem_data;
      end
   end

   // Request FSM with registered mem_rd/mem_addr/ioctl_din/ioctl_wait.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= StIdle;
         lat_cnt  <= '0;
         rd_data  <= '0;
         busy     <= 1'b0;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
      end else begin
         mem_rd <= 1'b0;
         unique case (state)
            StIdle: begin
               if (req) begin
                  if (in_range) begin
                     state    <= StIssue;
                     mem_rd   <= 1'b1;
                     mem_addr <= ioctl.ioctl_addr[CART_ADDR_W-1:0];
                     busy     <= 1'b1;
                  end else begin
                     rd_data <= FILL_BYTE;
                  end
               end
            end
            StIssue: begin
               if (!ioctl.ioctl_upload) begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end else begin
                  state   <= StFetch;
                  lat_cnt <= 3'd1;
               end
            end
            StFetch: begin
               // A dropped session abandons the fetch; the late byte is never taken.
               if (!ioctl.ioctl_upload) begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end else if (lat_cnt == 3'(MEM_LAT)) begin
                  rd_data <= mem_data;
                  state   <= StIdle;
                  busy    <= 1'b0;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Session bookkeeping: byte counter, optional checksum, end-of-session pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         byte_count  <= '0;
         upload_done <= 1'b0;
`ifdef CART_UPLOAD_CHECKSUM_EN
         checksum    <= '0;
`endif
      end else begin
         upload_done <= up_fall;
         if (up_rise) begin
            byte_count <= '0;
`ifdef CART_UPLOAD_CHECKSUM_EN
            checksum   <= '0;
`endif
         end else if (ret_valid) begin
            if (byte_count != 16'hFFFF) begin
               byte_count <= byte_count + 16'd1;
            end
`ifdef CART_UPLOAD_CHECKSUM_EN
            checksum <= checksum + ret_byte;
`endif
         end
      end
   end

   assign ioctl.ioctl_din  = rd_data;
   assign ioctl.ioctl_wait = busy;

endmodule

// File: tb/tb_cart_upload.sv
// Self-checking bench for cart_upload: directed corner cases plus randomized
// requests checked against a transaction-level model of the upload rules.
module tb_cart_upload;
   import vectrex_pkg::*;

   localparam int unsigned MemLat = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic [14:0] size_mask;
   logic [14:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data;
   logic [15:0] byte_count;
   logic        upload_done;
`ifdef CART_UPLOAD_CHECKSUM_EN
   logic [7:0]  checksum;
`endif

   cart_upload_if bus ();

   cart_upload #(
      .MEM_LAT (MemLat)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .ioctl       (bus),
      .size_mask   (size_mask),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_data    (mem_data),
      .byte_count  (byte_count),
      .upload_done (upload_done)
`ifdef CART_UPLOAD_CHECKSUM_EN
      ,
      .checksum    (checksum)
`endif
   );

   always #5 clock = ~clock;

   // Cart memory: read sampled on mem_rd, data appears MemLat cycles later;
   // garbage is presented on every other cycle.
   logic [7:0] ram      [0:32767];
   logic [7:0] mem_pipe [0:3];

   always @(posedge clock) begin
      mem_pipe[0] <= mem_rd ? ram[mem_addr] : 8'($urandom);
      for (int i = 1; i < 4; i++) mem_pipe[i] <= mem_pipe[i-1];
   end

   assign mem_data = mem_pipe[MemLat-1];

   int         n_total = 0;
   int         n_bad   = 0;
   int         exp_count;
   logic [7:0] exp_sum;
   logic [7:0] exp_din;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic model_return(input logic [7:0] b);
      if (exp_count < 65535) exp_count++;
      exp_sum = exp_sum + b;
      exp_din = b;
   endtask

   task automatic check_session();
      check_eq("byte_count", 32'(byte_count), 32'(exp_count));
`ifdef CART_UPLOAD_CHECKSUM_EN
      check_eq("checksum", 32'(checksum), 32'(exp_sum));
`endif
   endtask

   // One HPS read; optionally re-strobe rd one cycle later (must be ignored).
   task automatic do_req(input logic [24:0] addr, input logic [14:0] mask, input bit spurious);
      logic       in_range;
      logic [7:0] want;
      int         n_rd;
      int         n_wait;
      bit         ret;
      in_range = (addr <= {10'd0, mask});
      want     = in_range ? ram[addr[14:0]] : 8'hFF;
      size_mask      = mask;
      bus.ioctl_addr = addr;
      bus.ioctl_rd   = 1'b1;
      n_rd   = 0;
      n_wait = 0;
      ret    = 1'b0;
      for (int c = 0; c < 16 && !ret; c++) begin
         step();
         bus.ioctl_rd = spurious && in_range && (c == 0);
         if (c == 0) bus.ioctl_addr = 25'($urandom_range(0, 32767));
         size_mask = 15'($urandom);
         if (mem_rd) begin
            n_rd++;
            check_eq("mem_addr", 32'(mem_addr), 32'(addr));
         end
         if (bus.ioctl_wait) begin
            n_wait++;
            check_eq("din_hold", 32'(bus.ioctl_din), 32'(exp_din));
         end else begin
            ret = 1'b1;
         end
      end
      bus.ioctl_rd = 1'b0;
      check_eq("ret_seen", 32'(ret), 32'd1);
      check_eq("mem_rd_cnt", n_rd, in_range ? 32'd1 : 32'd0);
      check_eq("wait_cycles", n_wait, in_range ? MemLat + 1 : 32'd0);
      model_return(want);
      check_eq("din", 32'(bus.ioctl_din), 32'(exp_din));
      check_session();
   endtask

   task automatic new_session();
      bus.ioctl_upload = 1'b0;
      step();
      check_eq("done_pulse", 32'(upload_done), 32'd1);
      step();
      check_eq("done_clear", 32'(upload_done), 32'd0);
      bus.ioctl_upload = 1'b1;
      step();
      exp_count = 0;
      exp_sum   = 8'h00;
      check_session();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset            = 1'b1;
      bus.ioctl_upload = 1'b0;
      bus.ioctl_rd     = 1'b0;
      bus.ioctl_addr   = '0;
      size_mask        = '0;
      exp_count        = 0;
      exp_sum          = 8'h00;
      exp_din          = 8'h00;
      for (int i = 0; i < 32768; i++) ram[i] = 8'($urandom);
      repeat (3) step();
      reset = 1'b0;
      step();

      // Reset values
      check_eq("rst_din", 32'(bus.ioctl_din), 32'd0);
      check_eq("rst_wait", 32'(bus.ioctl_wait), 32'd0);
      check_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
      check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_done", 32'(upload_done), 32'd0);
      check_session();

      // rd without an upload session is ignored
      size_mask      = 15'h7FFF;
      bus.ioctl_addr = 25'h0010;
      bus.ioctl_rd   = 1'b1;
      step();
      bus.ioctl_rd = 1'b0;
      check_eq("noup_mem_rd", 32'(mem_rd), 32'd0);
      check_eq("noup_wait", 32'(bus.ioctl_wait), 32'd0);
      step();
      check_eq("noup_din", 32'(bus.ioctl_din), 32'(exp_din));
      check_session();

      // Session start, then basic in-range fetch
      bus.ioctl_upload = 1'b1;
      step();
      check_session();
      ram[15'h0123] = 8'hA5;
      do_req(25'h0123, 15'h0FFF, 1'b0);
      check_eq("a5_din", 32'(bus.ioctl_din), 32'h0A5);

      // Second rd one cycle after the first is dropped, in a fresh session
      new_session();
      do_req(25'h0456, 15'h0FFF, 1'b1);
      check_eq("spur_count", 32'(byte_count), 32'd1);

      // Just outside the mask: fill byte, no memory access
      do_req(25'h1000, 15'h0FFF, 1'b0);
      check_eq("oor_din", 32'(bus.ioctl_din), 32'h0FF);

      // Randomized requests over masks, in/out-of-range and high addresses
      for (int t = 0; t < 200; t++) begin
         int          n;
         int          sel;
         logic [14:0] m;
         logic [24:0] a;
         n   = $urandom_range(0, 15);
         m   = 15'((32'd1 << n) - 32'd1);
         sel = $urandom_range(0, 3);
         if (sel < 2) a = {10'd0, 15'($urandom) & m};
         else if (sel == 2) a = {10'd0, 15'($urandom)};
         else a = 25'($urandom);
         do_req(a, m, $urandom_range(0, 1) == 1);
         if ($urandom_range(0, 19) == 0) new_session();
      end

      // Upload dropped mid-fetch: abandon, keep old din, pulse done
      ram[15'h0042]  = ~exp_din;
      size_mask      = 15'h7FFF;
      bus.ioctl_addr = 25'h0042;
      bus.ioctl_rd   = 1'b1;
      step();
      bus.ioctl_rd = 1'b0;
      check_eq("abort_issue", 32'(bus.ioctl_wait), 32'd1);
      step();
      bus.ioctl_upload = 1'b0;
      step();
      check_eq("abort_wait", 32'(bus.ioctl_wait), 32'd0);
      check_eq("abort_din", 32'(bus.ioctl_din), 32'(exp_din));
      check_eq("abort_done", 32'(upload_done), 32'd1);
      check_session();
      step();
      check_eq("abort_done_clr", 32'(upload_done), 32'd0);
      repeat (MemLat + 2) begin
         step();
         check_eq("abort_late_din", 32'(bus.ioctl_din), 32'(exp_din));
         check_eq("abort_late_wait", 32'(bus.ioctl_wait), 32'd0);
      end
      bus.ioctl_upload = 1'b1;
      step();
      exp_count = 0;
      exp_sum   = 8'h00;
      check_session();

      // Reset during ISSUE: everything clears and the late byte is dropped
      ram[15'h0123]  = 8'hA5;
      size_mask      = 15'h0FFF;
      bus.ioctl_addr = 25'h0123;
      bus.ioctl_rd   = 1'b1;
      step();
      bus.ioctl_rd = 1'b0;
      check_eq("rst2_issue", 32'(mem_rd), 32'd1);
      reset = 1'b1;
      step();
      reset     = 1'b0;
      exp_count = 0;
      exp_sum   = 8'h00;
      exp_din   = 8'h00;
      check_eq("rst2_din", 32'(bus.ioctl_din), 32'd0);
      check_eq("rst2_wait", 32'(bus.ioctl_wait), 32'd0);
      check_eq("rst2_mem_rd", 32'(mem_rd), 32'd0);
      check_eq("rst2_mem_addr", 32'(mem_addr), 32'd0);
      check_eq("rst2_done", 32'(upload_done), 32'd0);
      check_session();
      repeat (MemLat + 3) begin
         step();
         check_eq("rst2_late_din", 32'(bus.ioctl_din), 32'd0);
         check_eq("rst2_late_wait", 32'(bus.ioctl_wait), 32'd0);
      end
      check_session();

`ifdef CART_UPLOAD_CHECKSUM_EN
      // Checksum wraps mod 256 and clears on a new session
      new_session();
      ram[15'h0001] = 8'hF0;
      ram[15'h0002] = 8'h20;
      ram[15'h0003] = 8'h01;
      do_req(25'h0001, 15'h7FFF, 1'b0);
      do_req(25'h0002, 15'h7FFF, 1'b0);
      do_req(25'h0003, 15'h7FFF, 1'b0);
      check_eq("cksum3", 32'(checksum), 32'h11);
      check_eq("cksum_cnt3", 32'(byte_count), 32'd3);
      new_session();
      check_eq("cksum_clr", 32'(checksum), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
